// File: rtl/cfg_frame_pkg.sv
// Shared definitions for the configuration frame loader: sync/end markers,
// header field positions, the controller state encoding and header helpers.
// The optional checksum stage is enabled by defining CFG_CHECKSUM_EN; the
// CHK encoding is always present so state dumps decode the same in every build.
package cfg_frame_pkg;

  // Word that opens a configuration session.
  localparam logic [31:0] SYNC_WORD = 32'hFAB0_FAB1;

  // Column value in a header that closes the session.
  localparam logic [7:0]  END_COL   = 8'hFF;

  // Header layout: [31:24] column, [7:0] number of frames.
  localparam int HDR_COL_MSB = 31;
  localparam int HDR_COL_LSB = 24;
  localparam int HDR_NF_MSB  = 7;
  localparam int HDR_NF_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_DATA   = 3'd2,
    ST_STROBE = 3'd3,
    ST_HOLD   = 3'd4,
    ST_CHK    = 3'd5
  } state_t;

  // Column field of a header word.
  function automatic logic [7:0] hdr_col(input logic [31:0] w);
    return w[HDR_COL_MSB:HDR_COL_LSB];
  endfunction

  // Frame-count field of a header word.
  function automatic logic [7:0] hdr_nframes(input logic [31:0] w);
    return w[HDR_NF_MSB:HDR_NF_LSB];
  endfunction

endpackage

// File: rtl/cfg_strobe_decoder.sv
// Combinational one-hot decoder from (column, frame, enable) to the fabric
// frame strobe vector. Bit index is col*MAX_FRAMES+frame; all zero when
// disabled or when the inputs point outside the fabric.
module cfg_strobe_decoder #(
  parameter int NUM_COLUMNS = 4,
  parameter int MAX_FRAMES  = 20,
  parameter int COL_W       = 2,
  parameter int NF_W        = 5
) (
  input  logic [COL_W-1:0]                  i_col,
  input  logic [NF_W-1:0]                   i_frame,
  input  logic                              i_en,
  output logic [NUM_COLUMNS*MAX_FRAMES-1:0] o_strobe
);

  // Exhaustive compare keeps the result one-hot by construction.
  always_comb begin
    o_strobe = '0;
    if (i_en) begin
      for (int c = 0; c < NUM_COLUMNS; c++) begin
        for (int f = 0; f < MAX_FRAMES; f++) begin
          if (i_col == COL_W'(c) && i_frame == NF_W'(f)) begin
            o_strobe[c*MAX_FRAMES+f] = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/cfg_frame_loader.sv
// Configuration frame loader: consumes a 32-bit word stream (valid/ready),
// assembles NUM_ROWS words into FrameData and fires one frame strobe per
// frame. Define CFG_CHECKSUM_EN to require an XOR checksum word per column.
//
// Handshake: a word transfers on a rising CLK edge where s_valid && s_ready.
// s_ready depends only on registered state, never on s_valid; the source may
// raise or drop s_valid at any cycle and a stalled word is simply not taken.
module cfg_frame_loader
  import cfg_frame_pkg::*;
#(
  parameter int NUM_ROWS      = 2,
  parameter int NUM_COLUMNS   = 4,
  parameter int MAX_FRAMES    = 20,
  parameter int STROBE_CYCLES = 2
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [31:0]                       s_data,
  input  logic                              s_valid,
  output logic                              s_ready,
  output logic [32*NUM_ROWS-1:0]            FrameData,
  output logic [NUM_COLUMNS*MAX_FRAMES-1:0] FrameStrobe,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  output state_t                            dbg_state
);

  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int COL_W = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1;
  localparam int NF_W  = $clog2(MAX_FRAMES + 1);
  localparam int SC_W  = $clog2(STROBE_CYCLES + 1);

  localparam logic [7:0]       NCOL_LIM = 8'(NUM_COLUMNS);
  localparam logic [7:0]       MAXF_LIM = 8'(MAX_FRAMES);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);
  localparam logic [SC_W-1:0]  LAST_SC  = SC_W'(STROBE_CYCLES - 1);

  // Registered state.
  state_t                r_state;
  logic                  r_live;
  logic [COL_W-1:0]      r_col;
  logic [NF_W-1:0]       r_nframes;
  logic [NF_W-1:0]       r_frame;
  logic [ROW_W-1:0]      r_row;
  logic [SC_W-1:0]       r_scnt;
  logic [32*NUM_ROWS-1:0] r_frame_data;
  logic                  r_done;
  logic                  r_err;
`ifdef CFG_CHECKSUM_EN
  logic [31:0]           r_chk;
`endif

  // Combinational control.
  state_t     w_state_nxt;
  logic       w_ready;
  logic       w_hdr_load;
  logic       w_data_wr;
  logic       w_frame_adv;
  logic       w_set_done;
  logic       w_set_err;
  logic       w_clr_err;
  logic [7:0] w_hdr_col;
  logic [7:0] w_hdr_nf;
  logic       w_hdr_bad;
  logic       w_last_row;
  logic       w_last_frame;
  logic       w_strobe_en;

  assign w_hdr_col    = hdr_col(s_data);
  assign w_hdr_nf     = hdr_nframes(s_data);
  assign w_hdr_bad    = (w_hdr_col >= NCOL_LIM) || (w_hdr_nf == 8'd0) ||
                        (w_hdr_nf > MAXF_LIM);
  assign w_last_row   = (r_row == LAST_ROW);
  assign w_last_frame = (r_frame == (r_nframes - NF_W'(1)));
  assign w_strobe_en  = (r_state == ST_STROBE);

  // State register; reset drops straight to IDLE, which kills the strobe.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-state control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_hdr_load  = 1'b0;
    w_data_wr   = 1'b0;
    w_frame_adv = 1'b0;
    w_set_done  = 1'b0;
    w_set_err   = 1'b0;
    w_clr_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // r_live keeps s_ready low until the first edge after reset.
        w_ready = r_live;
        if (r_live && s_valid && s_data == SYNC_WORD) begin
          w_clr_err   = 1'b1;
          w_state_nxt = ST_HDR;
        end
      end
      ST_HDR: begin
        w_ready = 1'b1;
        if (s_valid) begin
          if (w_hdr_col == END_COL) begin
            w_set_done  = 1'b1;
            w_state_nxt = ST_IDLE;
          end else if (w_hdr_bad) begin
            w_set_err   = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_hdr_load  = 1'b1;
            w_state_nxt = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        w_ready = 1'b1;
        if (s_valid) begin
          w_data_wr = 1'b1;
          if (w_last_row) begin
            w_state_nxt = ST_STROBE;
          end
        end
      end
      ST_STROBE: begin
        if (r_scnt == LAST_SC) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_last_frame) begin
`ifdef CFG_CHECKSUM_EN
          w_state_nxt = ST_CHK;
`else
          w_state_nxt = ST_HDR;
`endif
        end else begin
          w_frame_adv = 1'b1;
          w_state_nxt = ST_DATA;
        end
      end
`ifdef CFG_CHECKSUM_EN
      ST_CHK: begin
        w_ready = 1'b1;
        if (s_valid) begin
          if (s_data != r_chk) begin
            w_set_err   = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_HDR;
          end
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath: header latch, row assembly, strobe timer, frame counter, flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_live       <= 1'b0;
      r_col        <= '0;
      r_nframes    <= '0;
      r_frame      <= '0;
      r_row        <= '0;
      r_scnt       <= '0;
      r_frame_data <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_live <= 1'b1;
      r_done <= w_set_done;
      if (w_set_err) begin
        r_err <= 1'b1;
      end else if (w_clr_err) begin
        r_err <= 1'b0;
      end
      if (w_hdr_load) begin
        r_col     <= w_hdr_col[COL_W-1:0];
        r_nframes <= w_hdr_nf[NF_W-1:0];
        r_frame   <= '0;
        r_row     <= '0;
      end
      // FrameData only moves on an accepted DATA word, so it is frozen
      // through STROBE and HOLD.
      if (w_data_wr) begin
        r_frame_data[32*r_row +: 32] <= s_data;
        r_row <= w_last_row ? '0 : r_row + 1'b1;
      end
      if (r_state == ST_STROBE) begin
        r_scnt <= r_scnt + 1'b1;
      end else begin
        r_scnt <= '0;
      end
      if (w_frame_adv) begin
        r_frame <= r_frame + 1'b1;
      end
    end
  end

`ifdef CFG_CHECKSUM_EN
  // Running XOR of every data word of the current column.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_chk <= '0;
    end else if (w_hdr_load) begin
      r_chk <= '0;
    end else if (w_data_wr) begin
      r_chk <= r_chk ^ s_data;
    end
  end
`endif

  cfg_strobe_decoder #(
    .NUM_COLUMNS (NUM_COLUMNS),
    .MAX_FRAMES  (MAX_FRAMES),
    .COL_W       (COL_W),
    .NF_W        (NF_W)
  ) u_strobe_dec (
    .i_col    (r_col),
    .i_frame  (r_frame),
    .i_en     (w_strobe_en),
    .o_strobe (FrameStrobe)
  );

  assign s_ready   = w_ready;
  assign FrameData = r_frame_data;
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule
